// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: multiplexed 7-seg scanner with blanking and tear-free frame loads (option: LEADING_ZERO_BLANK_EN)
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  output logic                    o_ready,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n, pending, pending_n;
  logic [NUM_DIGITS-1:0] lz, en_n;
  logic [3:0] nib;
  logic [6:0] seg_n;
  logic slot_end, frame_end, commit, accept, ready_n, done_n;
  // zero digits above the highest nonzero one; digit 0 always shown
  always_comb begin
    lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = NUM_DIGITS - 1, bit z = 1'b1; k > 0; k--) begin
      z = z & (shadow_n[4*k +: 4] == 4'd0);
      lz[k] = z;
    end
`endif
  end
  // next scan position, frame buffers and the output values for that position
  always_comb begin
    slot_end  = cnt == CW'(CLK_DIV - 1);
    frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
    cnt_n     = slot_end ? '0 : cnt + CW'(1);
    idx_n     = !slot_end ? idx : (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    state_n   = slot_end ? BLANK : (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) ? SHOW : state;
    commit    = frame_end && !o_ready;
    accept    = i_load && o_ready;
    shadow_n  = commit ? pending : shadow;
    pending_n = accept ? i_digits : pending;
    ready_n   = commit ? 1'b1 : accept ? 1'b0 : o_ready;
    nib       = shadow_n[{idx_n, 2'b00} +: 4];
    seg_n     = (state_n == SHOW && !lz[idx_n]) ? ~SEG[nib] : 7'h7F;
    en_n      = state_n == SHOW ? ~(NUM_DIGITS'(1) << idx_n) : '1;
    done_n    = idx_n == IW'(NUM_DIGITS - 1) && cnt_n == CW'(CLK_DIV - 1);
  end
  // state and registered outputs; reset wins over any pending load
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      pending      <= '0;
      o_ready      <= 1'b1;
      o_seg        <= 7'h7F;
      o_dig_en     <= '1;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shadow       <= shadow_n;
      pending      <= pending_n;
      o_ready      <= ready_n;
      o_seg        <= seg_n;
      o_dig_en     <= en_n;
      o_frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: directed checks of scan timing, frame loads, decode and reset
module tb_seven_segment_scan_controller;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [15:0] digits = '0;
  logic ready, done;
  logic [6:0] seg;
  logic [3:0] dig_en;
  int n_checks = 0, n_fail = 0;
  seven_segment_scan_controller #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_digits(digits),
    .o_ready(ready), .o_seg(seg), .o_dig_en(dig_en), .o_frame_done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  // one full frame from slot 0 counter 0; segs = {d3,d2,d1,d0} expected o_seg while shown
  task automatic frame(input string tag, input logic [27:0] segs, input logic hold, input logic r0, input logic rm);
    logic [3:0] e_en;
    logic [6:0] e_seg;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++) begin
        e_en  = c < 2 ? 4'hF : ~(4'b0001 << s);
        e_seg = c < 2 ? 7'h7F : segs[7*s +: 7];
        check($sformatf("%s_en_d%0d_c%0d", tag, s, c), dig_en, e_en);
        check($sformatf("%s_seg_d%0d_c%0d", tag, s, c), seg, e_seg);
        check($sformatf("%s_done_d%0d_c%0d", tag, s, c), done, s == 3 && c == 7);
        check($sformatf("%s_ready_d%0d_c%0d", tag, s, c), ready, (s == 0 && c == 0) ? r0 : rm);
        step();
        if (s == 0 && c == 0) begin
          load = hold;
          if (hold) digits = 16'h1111;
        end
      end
  endtask
  initial begin
    repeat (3) step();
    check("rst_seg", seg, 7'h7F);
    check("rst_en", dig_en, 4'hF);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    load = 1'b1; digits = 16'h1234;
    frame("f0", {4{7'h40}}, 1'b0, 1'b1, 1'b0);
    load = 1'b1; digits = 16'hA9A9;
    frame("f1234", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0, 1'b1, 1'b0);
    load = 1'b1; digits = 16'h5678;
    frame("fA9A9", {7'h7F, 7'h10, 7'h7F, 7'h10}, 1'b1, 1'b1, 1'b0);
    load = 1'b1; digits = 16'h0042;
    frame("f5678", {7'h12, 7'h02, 7'h78, 7'h00}, 1'b0, 1'b1, 1'b0);
    load = 1'b1; digits = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
    frame("f0042", {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0, 1'b1, 1'b0);
    frame("f0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 1'b1, 1'b1);
`else
    frame("f0042", {7'h40, 7'h40, 7'h19, 7'h24}, 1'b0, 1'b1, 1'b0);
    frame("f0000", {4{7'h40}}, 1'b0, 1'b1, 1'b1);
`endif
    load = 1'b1; digits = 16'h9999;
    step();
    load = 1'b0;
    repeat (19) step();
    check("mid_en", dig_en, 4'hB);
    check("mid_ready", ready, 1'b0);
    rst_n = 1'b0;
    step();
    check("rst2_seg", seg, 7'h7F);
    check("rst2_en", dig_en, 4'hF);
    check("rst2_ready", ready, 1'b1);
    check("rst2_done", done, 1'b0);
    rst_n = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    frame("fpost", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 1'b1, 1'b1);
    frame("fpost2", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 1'b1, 1'b1);
`else
    frame("fpost", {4{7'h40}}, 1'b0, 1'b1, 1'b1);
    frame("fpost2", {4{7'h40}}, 1'b0, 1'b1, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
